// File: rtl/alu_seq_pkg.sv
// Shared types, instruction field positions and saturation helper for the ALU issue sequencer.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_NOT = 4'h6,
        OP_LDI = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL
    } state_e;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)
            return SAT_MAX;
        else if (v < -33'sd32768)
            return SAT_MIN;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// DEPTH x W synchronous instruction FIFO, show-ahead read, registered occupancy count.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// In-order ALU issue sequencer: FIFO-buffered instructions, register file, execute and retire.
// Define ALU_SEQ_SAT_EN to make ADD/SUB/MUL saturate instead of wrapping.
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO head when one is present
// EXEC  | instr_q executes; non-MUL retires this cycle, MUL latches operands
// MUL   | multiply in progress; retires on the cycle mul_cnt reaches zero
module alu_issue_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic        busy,
    output logic        ret_valid,
    output logic        ret_err,
    output logic [3:0]  ret_dst,
    output logic [15:0] ret_data,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e             state, state_nxt;
    logic [15:0]        instr_q;
    logic signed [15:0] regs [16];
    logic signed [15:0] mul_a, mul_b;
    logic [CNTW-1:0]    mul_cnt;

    logic [15:0]        fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic               pop, we, mul_start;

    opcode_e            op;
    logic [3:0]         ra_idx, rb_idx, rd_idx;
    logic [7:0]         imm;
    logic signed [15:0] opa, opb;
    logic [15:0]        add_res, sub_res, mul_res;

    alu_seq_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .wdata (in_instr),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE) || (fifo_count != '0);
    assign dbg_data = regs[dbg_addr];

    assign op     = opcode_e'(instr_q[OP_MSB:OP_LSB]);
    assign ra_idx = instr_q[RA_MSB:RA_LSB];
    assign rb_idx = instr_q[RB_MSB:RB_LSB];
    assign rd_idx = instr_q[RD_MSB:RD_LSB];
    assign imm    = instr_q[IMM_MSB:IMM_LSB];
    assign opa    = regs[ra_idx];
    assign opb    = regs[rb_idx];

`ifdef ALU_SEQ_SAT_EN
    logic signed [32:0] add_w, sub_w, mul_w;
    assign add_w   = 33'(opa) + 33'(opb);
    assign sub_w   = 33'(opa) - 33'(opb);
    assign mul_w   = 33'(mul_a) * 33'(mul_b);
    assign add_res = sat16(add_w);
    assign sub_res = sat16(sub_w);
    assign mul_res = sat16(mul_w);
`else
    // Low 16 bits of a product depend only on the low 16 bits of the operands.
    assign add_res = opa + opb;
    assign sub_res = opa - opb;
    assign mul_res = mul_a * mul_b;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        we        = 1'b0;
        mul_start = 1'b0;
        ret_valid = 1'b0;
        ret_err   = 1'b0;
        ret_dst   = '0;
        ret_data  = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (op == OP_MUL) begin
                    mul_start = 1'b1;
                    state_nxt = MUL;
                end else begin
                    ret_valid = 1'b1;
                    ret_dst   = rd_idx;
                    case (op)
                        OP_ADD:  ret_data = add_res;
                        OP_SUB:  ret_data = sub_res;
                        OP_AND:  ret_data = opa & opb;
                        OP_OR:   ret_data = opa | opb;
                        OP_XOR:  ret_data = opa ^ opb;
                        OP_NOT:  ret_data = ~opa;
                        OP_LDI: begin
                            ret_dst  = ra_idx;
                            ret_data = {8'h00, imm};
                        end
                        default: ret_err = 1'b1;
                    endcase
                    we        = !ret_err;
                    pop       = !fifo_empty;
                    state_nxt = fifo_empty ? IDLE : EXEC;
                end
            end
            MUL: begin
                if (mul_cnt == '0) begin
                    ret_valid = 1'b1;
                    ret_dst   = rd_idx;
                    ret_data  = mul_res;
                    we        = 1'b1;
                    pop       = !fifo_empty;
                    state_nxt = fifo_empty ? IDLE : EXEC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            instr_q <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_cnt <= '0;
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if (pop)
                instr_q <= fifo_rdata;
            if (mul_start) begin
                mul_a   <= opa;
                mul_b   <= opb;
                mul_cnt <= CNTW'(MUL_LAT - 1);
            end else if (state == MUL && mul_cnt != '0) begin
                mul_cnt <= mul_cnt - CNTW'(1);
            end
            if (we)
                regs[ret_dst] <= ret_data;
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Self-checking bench: directed scenarios plus randomized instruction streams vs. a retire-order model.
module tb_alu_issue_sequencer;
    localparam int DEPTH   = 4;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = '0;
    logic [3:0]  dbg_addr = '0;
    logic        in_ready, busy, ret_valid, ret_err;
    logic [3:0]  ret_dst;
    logic [15:0] ret_data, dbg_data;

    always #5 clk = ~clk;

    alu_issue_sequencer #(.DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .busy      (busy),
        .ret_valid (ret_valid),
        .ret_err   (ret_err),
        .ret_dst   (ret_dst),
        .ret_data  (ret_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural registers updated in retire order.
    typedef struct { logic [15:0] ins; int cyc; } ent_t;
    typedef struct { int cyc; logic [3:0] dst; logic [15:0] data; logic err; } ret_t;

    logic [15:0] m_regs [16];
    ent_t        exp_q [$];
    ret_t        ret_log [$];
    int          cyc = 0;
    int          last_push_cyc = 0;

    function automatic int clampi(input int v);
`ifdef ALU_SEQ_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
`endif
        return v;
    endfunction

    function automatic void model_exec(input logic [15:0] ins, output logic err,
                                       output logic [3:0] dst, output logic [15:0] data);
        int a, b, r;
        a   = $signed(m_regs[ins[11:8]]);
        b   = $signed(m_regs[ins[7:4]]);
        r   = 0;
        err = 1'b0;
        dst = ins[3:0];
        case (ins[15:12])
            4'h0: r = clampi(a + b);
            4'h1: r = clampi(a - b);
            4'h2: r = clampi(a * b);
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            4'h6: r = ~a;
            4'hF: begin dst = ins[11:8]; r = int'(ins[7:0]); end
            default: err = 1'b1;
        endcase
        data = r[15:0];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back('{ins: in_instr, cyc: cyc});
            last_push_cyc = cyc;
        end
    end

    ent_t        mon_e;
    logic        mon_err;
    logic [3:0]  mon_dst;
    logic [15:0] mon_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            check("ret_valid_in_reset", ret_valid, 0);
        end else if (ret_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_retire", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                model_exec(mon_e.ins, mon_err, mon_dst, mon_data);
                check("ret_err", ret_err, mon_err);
                if (!mon_err) begin
                    check("ret_dst", ret_dst, mon_dst);
                    check("ret_data", ret_data, mon_data);
                    m_regs[mon_dst] = mon_data;
                end
                ret_log.push_back('{cyc: cyc, dst: ret_dst, data: ret_data, err: ret_err});
            end
        end
    end

    task automatic push(input logic [15:0] ins, output int stall);
        in_valid = 1'b1;
        in_instr = ins;
        stall    = 0;
        while (!in_ready && stall < 500) begin
            @(negedge clk);
            stall++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check(tag, dbg_data, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        int          s5;
        logic [15:0] v;
        logic [3:0]  op;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_ret_err", ret_err, 0);
        check("rst_ret_dst", ret_dst, 0);
        check("rst_ret_data", ret_data, 0);
        check_regs_zero("rst_dbg");

        ret_log.delete();
        push(16'hF002, st);
        push(16'hF107, st);
        push(16'h0013, st);
        wait_idle();
        check("ldi_add_count", ret_log.size(), 3);
        check("ldi0_dst", ret_log[0].dst, 0);
        check("ldi0_data", ret_log[0].data, 2);
        check("ldi1_dst", ret_log[1].dst, 1);
        check("ldi1_data", ret_log[1].data, 7);
        check("add_dst", ret_log[2].dst, 3);
        check("add_data", ret_log[2].data, 9);
        check("consec_1", ret_log[1].cyc - ret_log[0].cyc, 1);
        check("consec_2", ret_log[2].cyc - ret_log[1].cyc, 1);
        check("add_latency", ret_log[2].cyc - last_push_cyc, 2);

        ret_log.delete();
        push(16'h1013, st);
        wait_idle();
        check("sub_data", ret_log[0].data, 16'hFFFB);

        ret_log.delete();
        push(16'h2013, st);
        wait_idle();
        check("mul_count", ret_log.size(), 1);
        check("mul_data", ret_log[0].data, 14);
        check("mul_latency", ret_log[0].cyc - last_push_cyc, 2 + MUL_LAT);

        ret_log.delete();
        push(16'h3013, st);
        push(16'h4013, st);
        push(16'h5013, st);
        push(16'h6003, st);
        wait_idle();
        check("and_data", ret_log[0].data, 2);
        check("or_data", ret_log[1].data, 7);
        check("xor_data", ret_log[2].data, 5);
        check("not_data", ret_log[3].data, 16'hFFFD);

        ret_log.delete();
        push(16'h7013, st);
        wait_idle();
        check("illegal_err", ret_log[0].err, 1);
        dbg_addr = 4'd3;
        #1;
        check("illegal_r3_kept", dbg_data, 16'hFFFD);
        @(negedge clk);

        // One MUL in flight, four queue behind it, the fifth must wait for the MUL retire pop.
        push(16'h2013, st);
        for (int k = 0; k < DEPTH; k++) begin
            push(16'h3013, st);
            check("fifo_accept_no_stall", st, 0);
        end
        push(16'h5013, s5);
        check("fifo_full_stall", s5, 1);
        wait_idle();
        check("fifo_drained", exp_q.size(), 0);

        ret_log.delete();
        push(16'hF4FF, st);
        push(16'h2445, st);
        wait_idle();
`ifdef ALU_SEQ_SAT_EN
        check("mul_sat", ret_log[1].data, 16'h7FFF);
`else
        check("mul_wrap", ret_log[1].data, 16'hFE01);
`endif

        for (int n = 0; n < 300; n++) begin
            v  = 16'($urandom());
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = 4'hF;
            v[15:12] = op;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push(v, st);
        end
        wait_idle();
        check("rand_drained", exp_q.size(), 0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check("rand_regfile", dbg_data, m_regs[i]);
        end
        @(negedge clk);

        push(16'h2445, st);
        repeat (2) @(negedge clk);
        check("mid_mul_busy", busy, 1);
        ret_log.delete();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (MUL_LAT + 3) @(negedge clk);
        check("abort_no_retire", ret_log.size(), 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check_regs_zero("abort_dbg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
